// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: Mealy clock-enable / flush control for IF/ID, ID/EX, EX/BEQ, MEM/WB and PC.
// Resolves load-use stalls, taken-branch squashes, memory waits and debug halt; counts frozen-PC cycles.

// state     | meaning
// ----------+------------------------------------------------------------
// RUN       | normal issue; hazards resolved combinationally by priority
// STALL_MEM | data memory busy; whole pipe frozen until one cycle after ready
// HALT      | debug halt; whole pipe frozen until resume
// UNUSED    | illegal encoding; frozen like HALT, returns to RUN on next Tick
module pipeline_hazard_ctrl #(
  parameter int CntBits = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Tick,
  input  logic               halt_req,
  input  logic               resume,
  input  logic               mem_busy,
  input  logic               branch_taken,
  input  logic               load_use,
  output logic               en_pc,
  output logic               en_ifid,
  output logic               en_idex,
  output logic               en_exmem,
  output logic               en_memwb,
  output logic               flush_ifid,
  output logic               flush_idex,
  output logic               pc_sel_branch,
  output logic [1:0]         state,
  output logic [CntBits-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    STALL_MEM = 2'd1,
    HALT      = 2'd2,
    UNUSED    = 2'd3
  } state_e;

  localparam logic [CntBits-1:0] CntMax = '1;
  localparam logic [CntBits-1:0] CntOne = {{(CntBits-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [CntBits-1:0] cnt_q, cnt_d;

  logic en_pc_c, en_ifid_c, en_idex_c, en_exmem_c, en_memwb_c;
  logic flush_ifid_c, flush_idex_c, pc_sel_c;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    en_pc_c      = 1'b0;
    en_ifid_c    = 1'b0;
    en_idex_c    = 1'b0;
    en_exmem_c   = 1'b0;
    en_memwb_c   = 1'b0;
    flush_ifid_c = 1'b0;
    flush_idex_c = 1'b0;
    pc_sel_c     = 1'b0;
    if (Tick) begin
      case (state_q)
        RUN: begin
          if (halt_req) begin
            state_d = HALT;
          end else if (mem_busy) begin
            state_d = STALL_MEM;
          end else if (branch_taken) begin
            en_pc_c      = 1'b1;
            en_ifid_c    = 1'b1;
            en_idex_c    = 1'b1;
            en_exmem_c   = 1'b1;
            en_memwb_c   = 1'b1;
            flush_ifid_c = 1'b1;
            flush_idex_c = 1'b1;
            pc_sel_c     = 1'b1;
          end else if (load_use) begin
            // hold PC and IF/ID, inject one bubble into ID/EX
            en_idex_c    = 1'b1;
            en_exmem_c   = 1'b1;
            en_memwb_c   = 1'b1;
            flush_idex_c = 1'b1;
          end else begin
            en_pc_c    = 1'b1;
            en_ifid_c  = 1'b1;
            en_idex_c  = 1'b1;
            en_exmem_c = 1'b1;
            en_memwb_c = 1'b1;
          end
        end
        STALL_MEM: begin
          // exit cycle stays frozen; branch/load-use are re-evaluated back in RUN
          if (!mem_busy) state_d = RUN;
        end
        HALT: begin
          if (resume) state_d = RUN;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (Tick && !en_pc_c && (cnt_q != CntMax)) cnt_d = cnt_q + CntOne;
  end

  // Reset input gates outputs directly so enables cannot pulse during reset
  assign en_pc         = en_pc_c      & ~Reset;
  assign en_ifid       = en_ifid_c    & ~Reset;
  assign en_idex       = en_idex_c    & ~Reset;
  assign en_exmem      = en_exmem_c   & ~Reset;
  assign en_memwb      = en_memwb_c   & ~Reset;
  assign flush_ifid    = flush_ifid_c & ~Reset;
  assign flush_idex    = flush_idex_c & ~Reset;
  assign pc_sel_branch = pc_sel_c     & ~Reset;

  assign state     = state_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl; a second instance with CntBits=4 checks saturation.
module tb_pipeline_hazard_ctrl;

  logic Clock, Reset, Tick, halt_req, resume, mem_busy, branch_taken, load_use;
  logic en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, pc_sel_branch;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic e4_pc, e4_ifid, e4_idex, e4_exmem, e4_memwb, f4_ifid, f4_idex, p4_sel;
  logic [1:0]  state4;
  logic [3:0]  stall_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_hazard_ctrl #(.CntBits(16)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .halt_req(halt_req), .resume(resume),
    .mem_busy(mem_busy), .branch_taken(branch_taken), .load_use(load_use),
    .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem),
    .en_memwb(en_memwb), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .pc_sel_branch(pc_sel_branch), .state(state), .stall_cnt(stall_cnt)
  );

  pipeline_hazard_ctrl #(.CntBits(4)) dut4 (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .halt_req(halt_req), .resume(resume),
    .mem_busy(mem_busy), .branch_taken(branch_taken), .load_use(load_use),
    .en_pc(e4_pc), .en_ifid(e4_ifid), .en_idex(e4_idex), .en_exmem(e4_exmem),
    .en_memwb(e4_memwb), .flush_ifid(f4_ifid), .flush_idex(f4_idex),
    .pc_sel_branch(p4_sel), .state(state4), .stall_cnt(stall_cnt4)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic       t, h, r, mb, bt, lu;
    logic [4:0] en;   // {pc, ifid, idex, exmem, memwb}
    logic [1:0] fl;   // {ifid, idex}
    logic       ps;
    logic [1:0] st;
    int         cnt;  // value before the edge
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic t, h, r, mb, bt, lu,
                     input logic [4:0] en, input logic [1:0] fl, input logic ps,
                     input logic [1:0] st, input int cnt);
    vec_t v;
    v.t = t; v.h = h; v.r = r; v.mb = mb; v.bt = bt; v.lu = lu;
    v.en = en; v.fl = fl; v.ps = ps; v.st = st; v.cnt = cnt;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d got=0x%0h expected=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic t, h, r, mb, bt, lu);
    Tick = t; halt_req = h; resume = r; mem_busy = mb; branch_taken = bt; load_use = lu;
  endtask

  function automatic logic [4:0] en_main();
    return {en_pc, en_ifid, en_idex, en_exmem, en_memwb};
  endfunction

  function automatic logic [4:0] en_small();
    return {e4_pc, e4_ifid, e4_idex, e4_exmem, e4_memwb};
  endfunction

  initial begin
    int sat;

    // 1-10 idle after reset
    for (int i = 0; i < 10; i++) add(1,0,0,0,0,0, 5'b11111, 2'b00, 0, 2'd0, 0);
    add(1,0,0,0,0,1, 5'b00111, 2'b01, 0, 2'd0, 0);   // load-use bubble
    add(1,0,0,0,0,0, 5'b11111, 2'b00, 0, 2'd0, 1);
    add(1,0,0,0,1,1, 5'b11111, 2'b11, 1, 2'd0, 1);   // branch beats load-use
    add(1,0,0,0,0,0, 5'b11111, 2'b00, 0, 2'd0, 1);
    add(1,0,0,1,0,0, 5'b00000, 2'b00, 0, 2'd0, 1);   // mem_busy x3
    add(1,0,0,1,0,0, 5'b00000, 2'b00, 0, 2'd1, 2);
    add(1,0,0,1,1,0, 5'b00000, 2'b00, 0, 2'd1, 3);   // branch ignored while stalled
    add(1,0,0,0,0,0, 5'b00000, 2'b00, 0, 2'd1, 4);   // exit cycle still frozen
    add(1,0,0,0,0,0, 5'b11111, 2'b00, 0, 2'd0, 5);
    add(1,1,0,0,0,0, 5'b00000, 2'b00, 0, 2'd0, 5);   // halt request
    add(1,0,0,0,0,0, 5'b00000, 2'b00, 0, 2'd2, 6);
    add(1,0,0,0,0,0, 5'b00000, 2'b00, 0, 2'd2, 7);
    add(1,0,0,0,0,0, 5'b00000, 2'b00, 0, 2'd2, 8);
    add(1,0,0,0,0,0, 5'b00000, 2'b00, 0, 2'd2, 9);
    add(0,0,1,0,0,0, 5'b00000, 2'b00, 0, 2'd2, 10);  // Tick=0: resume not seen
    add(0,0,0,0,0,0, 5'b00000, 2'b00, 0, 2'd2, 10);
    add(1,1,1,0,0,0, 5'b00000, 2'b00, 0, 2'd2, 10);  // resume wins over halt_req
    add(1,0,0,0,0,0, 5'b11111, 2'b00, 0, 2'd0, 11);
    add(1,1,0,0,0,0, 5'b00000, 2'b00, 0, 2'd0, 11);  // halt again to reach saturation
    add(1,0,0,0,0,0, 5'b00000, 2'b00, 0, 2'd2, 12);
    add(1,0,0,0,0,0, 5'b00000, 2'b00, 0, 2'd2, 13);
    add(1,0,0,0,0,0, 5'b00000, 2'b00, 0, 2'd2, 14);
    add(1,0,0,0,0,0, 5'b00000, 2'b00, 0, 2'd2, 15);
    add(1,0,1,0,0,0, 5'b00000, 2'b00, 0, 2'd2, 16);
    add(1,0,0,0,0,0, 5'b11111, 2'b00, 0, 2'd0, 17);
    add(0,0,0,0,0,1, 5'b00000, 2'b00, 0, 2'd0, 17);  // Tick=0 masks hazards
    add(0,0,0,1,1,0, 5'b00000, 2'b00, 0, 2'd0, 17);
    add(1,0,0,0,0,0, 5'b11111, 2'b00, 0, 2'd0, 17);

    Reset = 1'b1;
    drive(1,0,0,0,0,0);
    #12;
    check("rst_en",    -1, {27'd0, en_main()}, 32'd0);
    check("rst_flush", -1, {30'd0, flush_ifid, flush_idex}, 32'd0);
    check("rst_pcsel", -1, {31'd0, pc_sel_branch}, 32'd0);
    check("rst_state", -1, {30'd0, state}, 32'd0);
    check("rst_cnt",   -1, {16'd0, stall_cnt}, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].t, vq[i].h, vq[i].r, vq[i].mb, vq[i].bt, vq[i].lu);
      #2;
      sat = (vq[i].cnt > 15) ? 15 : vq[i].cnt;
      check("en",    i, {27'd0, en_main()}, {27'd0, vq[i].en});
      check("flush", i, {30'd0, flush_ifid, flush_idex}, {30'd0, vq[i].fl});
      check("pcsel", i, {31'd0, pc_sel_branch}, {31'd0, vq[i].ps});
      check("state", i, {30'd0, state}, {30'd0, vq[i].st});
      check("cnt",   i, {16'd0, stall_cnt}, vq[i].cnt);
      check("cnt4",  i, {28'd0, stall_cnt4}, sat);
      check("en4",   i, {27'd0, en_small()}, {27'd0, vq[i].en});
      @(negedge Clock);
    end

    // asynchronous reset between edges while in STALL_MEM
    drive(1,0,0,1,0,0);
    @(negedge Clock);
    #1;
    check("stall_entered", 100, {30'd0, state}, 32'd1);
    drive(1,0,0,0,0,0);
    #1;
    Reset = 1'b1;
    #1;
    check("arst_state", 100, {30'd0, state}, 32'd0);
    check("arst_cnt",   100, {16'd0, stall_cnt}, 32'd0);
    check("arst_cnt4",  100, {28'd0, stall_cnt4}, 32'd0);
    check("arst_en",    100, {27'd0, en_main()}, 32'd0);   // RUN+idle would enable all
    @(posedge Clock);
    #1;
    check("rst_hold_en", 101, {27'd0, en_main()}, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    #2;
    check("post_state", 102, {30'd0, state}, 32'd0);
    check("post_cnt",   102, {16'd0, stall_cnt}, 32'd0);
    check("post_en",    102, {27'd0, en_main()}, 32'h1f);
    @(negedge Clock);
    #2;
    check("post_cnt2",  103, {16'd0, stall_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencing block for the CPU pipeline registers: IF/ID, ID/EX, EX/BEQ and MEM/WB.
- Drives the ClockEnable of every pipeline register and the PC, and the synchronous flush (NOP-load) requests for IF/ID and ID/EX.
- Resolves load-use stalls, BEQ-taken squashes, multi-cycle memory waits and debug halt.
- Sits beside the datapath; all pipeline registers share its Clock, Reset and Tick.

Parameters:
CntBits, 16, width of the saturating stall-cycle counter (legal range 4..32)

Ports:
Clock  input  1  system clock, all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
Tick  input  1  global clock-enable qualifier; no state advance when 0
halt_req  input  1  debug halt request, level
resume  input  1  leave HALT, level
mem_busy  input  1  data memory not ready this cycle
branch_taken  input  1  BEQ in EX resolved taken (from EX/BEQ stage comparator)
load_use  input  1  instruction in ID depends on load in EX
en_pc  output  1  PC clock enable
en_ifid  output  1  IF/ID register clock enable
en_idex  output  1  ID/EX register clock enable
en_exmem  output  1  EX/BEQ register clock enable
en_memwb  output  1  MEM/WB register clock enable
flush_ifid  output  1  IF/ID loads NOP at next edge (qualified by en_ifid)
flush_idex  output  1  ID/EX loads NOP at next edge (qualified by en_idex)
pc_sel_branch  output  1  PC mux selects branch target
state  output  2  FSM state: 0 RUN, 1 STALL_MEM, 2 HALT
stall_cnt  output  CntBits  cycles with en_pc=0 while Tick=1, saturating

Behaviour:
- Reset asserted: state=RUN, stall_cnt=0; all en_*, flush_*, pc_sel_branch forced to 0 asynchronously for the duration of Reset.
- Outputs are combinational from state and inputs (Mealy), so a decision takes effect on the same Clock edge; state and stall_cnt are registered.
- Tick=0: all en_*, flush_*, pc_sel_branch = 0; state and stall_cnt hold.
- RUN with Tick=1, evaluated in this priority order:
  1. halt_req: all en_* = 0, no flush; next state HALT.
  2. mem_busy: all en_* = 0; next state STALL_MEM.
  3. branch_taken: all en_* = 1, pc_sel_branch = 1, flush_ifid = flush_idex = 1 (2-bubble penalty); load_use ignored.
  4. load_use: en_pc = en_ifid = 0; en_idex = en_exmem = en_memwb = 1; flush_idex = 1 (one bubble); stays RUN.
  5. Otherwise: all en_* = 1, no flush.
- STALL_MEM: all en_* and flush_* = 0, pc_sel_branch = 0.
  - Tick=1 and mem_busy=0: next state RUN. Enables stay 0 in this exit cycle, so N busy cycles cost N+1 frozen cycles.
  - branch_taken, load_use and halt_req are ignored. Frozen registers hold their sources; they are re-evaluated in RUN.
- HALT: all en_* = 0. Tick=1 and resume=1: next state RUN. halt_req and resume both high: resume wins.
- stall_cnt increments by 1 on every Clock edge with Tick=1 and en_pc=0, in all states. It saturates at 2^CntBits-1; no wrap.
- Unused state encoding 3: behaves as HALT with enables 0, next state RUN on the next Tick.
- Reset mid-stall or mid-halt: immediate return to RUN; counter cleared.
- Enables never glitch high during Reset: output gating uses the Reset input directly.

Test Plan:
- Reset release, Tick=1, no hazards: all en_* = 1 on every cycle, flush_* = 0, state=0, stall_cnt stays 0 after 10 cycles.
- load_use high for 1 cycle: that cycle en_pc=en_ifid=0, flush_idex=1, en_idex=en_exmem=en_memwb=1; stall_cnt becomes 1; next cycle all enables 1.
- branch_taken and load_use both high for 1 cycle: pc_sel_branch=1, flush_ifid=flush_idex=1, all en_*=1; stall_cnt unchanged.
- mem_busy high for 3 cycles: enables 0 for 4 cycles, state=1 for 3 cycles, then RUN; stall_cnt=4. branch_taken pulsed mid-wait produces no flush.
- halt_req for 1 cycle, then resume after 5 cycles: state=2 and enables 0 until resume; state=0 next cycle. With Tick=0 while halted, state and stall_cnt hold. With CntBits=4, the counter saturates at 15.
- Assert Reset asynchronously during STALL_MEM (between edges): enables 0 immediately, state=0 and stall_cnt=0 after release.
